// File: rtl/code_entry_if.sv
// rtl/code_entry_if.sv - switch code and enter button in, checked code and status out
interface code_entry_if;
  logic [15:0] code;
  logic        enter_button;
  logic [15:0] code_out;
  logic        code_valid;
  logic        code_error;
  logic [1:0]  err_reason;
  logic        busy;

  modport master (
    output code, enter_button,
    input  code_out, code_valid, code_error, err_reason, busy
  );

  modport slave (
    input  code, enter_button,
    output code_out, code_valid, code_error, err_reason, busy
  );
endinterface

// File: rtl/code_entry.sv
// rtl/code_entry.sv - debounced enter button, code capture and repeated-digit check
// Optional range check of digits > 9 enabled by CODE_BCD_CHECK_EN.
module code_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset,
  code_entry_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       PAIR_LAST = 3'd5;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [2:0]       pair_q, pair_d;
  logic             dup_q, dup_d;
  logic [15:0]      code_out_q, code_out_d;
  logic             code_valid_q, code_valid_d;
  logic             code_error_q, code_error_d;
  logic [1:0]       err_reason_q, err_reason_d;
  logic             busy_q, busy_d;
  logic             press;
  logic [3:0]       dig_a, dig_b;
`ifdef CODE_BCD_CHECK_EN
  logic             bcd_q, bcd_d;
`endif

  // The level only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    sync1_d     = bus.enter_button;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    level_dly_d = level_q;
    press       = level_q & ~level_dly_q;
  end

  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    case (pair_q)
      3'd0:    begin dig_a = shadow_q[15:12]; dig_b = shadow_q[11:8]; end
      3'd1:    begin dig_a = shadow_q[15:12]; dig_b = shadow_q[7:4];  end
      3'd2:    begin dig_a = shadow_q[15:12]; dig_b = shadow_q[3:0];  end
      3'd3:    begin dig_a = shadow_q[11:8];  dig_b = shadow_q[7:4];  end
      3'd4:    begin dig_a = shadow_q[11:8];  dig_b = shadow_q[3:0];  end
      default: begin dig_a = shadow_q[7:4];   dig_b = shadow_q[3:0];  end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    pair_d       = pair_q;
    dup_d        = dup_q;
    code_out_d   = code_out_q;
    code_valid_d = 1'b0;
    code_error_d = 1'b0;
    err_reason_d = 2'd0;
`ifdef CODE_BCD_CHECK_EN
    bcd_d        = bcd_q;
`endif
    case (state_q)
      IDLE: begin
        if (press) begin
          shadow_d = bus.code;
          pair_d   = 3'd0;
          dup_d    = 1'b0;
          state_d  = CHECK;
`ifdef CODE_BCD_CHECK_EN
          bcd_d    = (bus.code[15:12] > 4'd9) || (bus.code[11:8] > 4'd9) ||
                     (bus.code[7:4]   > 4'd9) || (bus.code[3:0]  > 4'd9);
`endif
        end
      end
      CHECK: begin
        dup_d = dup_q | (dig_a == dig_b);
        if (pair_q == PAIR_LAST) begin
          state_d = REPORT;
        end else begin
          pair_d = pair_q + 3'd1;
        end
      end
      REPORT: begin
        state_d = IDLE;
`ifdef CODE_BCD_CHECK_EN
        if (bcd_q) begin
          code_error_d = 1'b1;
          err_reason_d = 2'd2;
        end else
`endif
        if (dup_q) begin
          code_error_d = 1'b1;
          err_reason_d = 2'd1;
        end else begin
          code_valid_d = 1'b1;
          code_out_d   = shadow_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_dly_q  <= 1'b0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      shadow_q     <= 16'h0000;
      pair_q       <= 3'd0;
      dup_q        <= 1'b0;
      code_out_q   <= 16'h0000;
      code_valid_q <= 1'b0;
      code_error_q <= 1'b0;
      err_reason_q <= 2'd0;
      busy_q       <= 1'b0;
`ifdef CODE_BCD_CHECK_EN
      bcd_q        <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_dly_q  <= level_dly_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      pair_q       <= pair_d;
      dup_q        <= dup_d;
      code_out_q   <= code_out_d;
      code_valid_q <= code_valid_d;
      code_error_q <= code_error_d;
      err_reason_q <= err_reason_d;
      busy_q       <= busy_d;
`ifdef CODE_BCD_CHECK_EN
      bcd_q        <= bcd_d;
`endif
    end
  end

  assign bus.code_out   = code_out_q;
  assign bus.code_valid = code_valid_q;
  assign bus.code_error = code_error_q;
  assign bus.err_reason = err_reason_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_code_entry.sv
// tb/tb_code_entry.sv - directed tests of code_entry debounce, capture, check and reporting
`timescale 1ns/1ps
module tb_code_entry;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  code_entry_if if0 ();
  code_entry_if if1 ();

  code_entry #(.DEBOUNCE_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(if0));
  code_entry #(.DEBOUNCE_CYCLES(2)) dut_fast (.clock(clock), .reset(reset), .bus(if1));

  int tests_run = 0;
  int tests_failed = 0;
  int k;
  int n_valid [2];
  int n_err [2];
  int n_busy [2];
  int valid_k [2];
  int err_k [2];
  int viol [2];
  logic [15:0] valid_code [2];
  logic [1:0]  err_rsn [2];

  task automatic clear_mon();
    k = 0;
    for (int i = 0; i < 2; i++) begin
      n_valid[i] = 0; n_err[i] = 0; n_busy[i] = 0;
      valid_k[i] = -1; err_k[i] = -1; viol[i] = 0;
      valid_code[i] = 16'hxxxx; err_rsn[i] = 2'bxx;
    end
  endtask

  task automatic sample(input int i, input logic v, input logic e, input logic [1:0] r,
                        input logic [15:0] co, input logic b);
    if (v) begin n_valid[i]++; valid_k[i] = k; valid_code[i] = co; end
    if (e) begin n_err[i]++; err_k[i] = k; err_rsn[i] = r; end
    if ((v && e) || (!e && r != 2'd0)) viol[i]++;
    if (b) n_busy[i]++;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    k++;
    sample(0, if0.code_valid, if0.code_error, if0.err_reason, if0.code_out, if0.busy);
    sample(1, if1.code_valid, if1.code_error, if1.err_reason, if1.code_out, if1.busy);
  endtask

  // Holds the dut button for `hold` cycles with `c` on the switches, then runs to `total`.
  task automatic press_run(input logic [15:0] c, input int hold, input int total);
    clear_mon();
    if0.code = c;
    if0.enter_button = 1'b1;
    while (k < total) begin
      tick();
      if (k == hold) if0.enter_button = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests_run++; if (if0.code_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_code_out: got %h expected 0000", if0.code_out); end
    tests_run++; if (if0.code_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_code_valid: got %b expected 0", if0.code_valid); end
    tests_run++; if (if0.code_error !== 1'b0) begin tests_failed++; $display("FAIL reset_code_error: got %b expected 0", if0.code_error); end
    tests_run++; if (if0.err_reason !== 2'd0) begin tests_failed++; $display("FAIL reset_err_reason: got %0d expected 0", if0.err_reason); end
    tests_run++; if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", if0.busy); end
    tests_run++; if (if1.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_fast: got %b expected 0", if1.busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    clear_mon();
    if0.code = 16'h1234;
    repeat (4) begin
      if0.enter_button = 1'b1;
      repeat (3) tick();
      if0.enter_button = 1'b0;
      repeat (5) tick();
    end
    tests_run++; if (n_busy[0] !== 0) begin tests_failed++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", n_busy[0]); end
    tests_run++; if (n_valid[0] !== 0) begin tests_failed++; $display("FAIL glitch_valid: got %0d pulses expected 0", n_valid[0]); end
    tests_run++; if (n_err[0] !== 0) begin tests_failed++; $display("FAIL glitch_error: got %0d pulses expected 0", n_err[0]); end
  endtask

  task automatic test_valid();
    logic b6, b7, b13, b14;
    clear_mon();
    if0.code = 16'h1234;
    if0.enter_button = 1'b1;
    while (k < 30) begin
      tick();
      if (k == 10) if0.enter_button = 1'b0;
      if (k == 6)  b6  = if0.busy;
      if (k == 7)  b7  = if0.busy;
      if (k == 13) b13 = if0.busy;
      if (k == 14) b14 = if0.busy;
    end
    tests_run++; if (n_valid[0] !== 1) begin tests_failed++; $display("FAIL valid_count: got %0d expected 1", n_valid[0]); end
    tests_run++; if (valid_k[0] !== 14) begin tests_failed++; $display("FAIL valid_latency: got cycle %0d expected 14", valid_k[0]); end
    tests_run++; if (valid_code[0] !== 16'h1234) begin tests_failed++; $display("FAIL valid_code_out: got %h expected 1234", valid_code[0]); end
    tests_run++; if (n_err[0] !== 0) begin tests_failed++; $display("FAIL valid_no_error: got %0d expected 0", n_err[0]); end
    tests_run++; if ({b6, b7, b13, b14} !== 4'b0110) begin tests_failed++; $display("FAIL valid_busy_window: got %b expected 0110", {b6, b7, b13, b14}); end
    tests_run++; if (viol[0] !== 0) begin tests_failed++; $display("FAIL valid_pulse_rules: got %0d violations expected 0", viol[0]); end
  endtask

  task automatic test_dup();
    press_run(16'h1231, 10, 30);
    tests_run++; if (n_err[0] !== 1) begin tests_failed++; $display("FAIL dup_count: got %0d expected 1", n_err[0]); end
    tests_run++; if (err_k[0] !== 14) begin tests_failed++; $display("FAIL dup_latency: got cycle %0d expected 14", err_k[0]); end
    tests_run++; if (err_rsn[0] !== 2'd1) begin tests_failed++; $display("FAIL dup_reason: got %0d expected 1", err_rsn[0]); end
    tests_run++; if (n_valid[0] !== 0) begin tests_failed++; $display("FAIL dup_no_valid: got %0d expected 0", n_valid[0]); end
    tests_run++; if (if0.code_out !== 16'h1234) begin tests_failed++; $display("FAIL dup_code_out_kept: got %h expected 1234", if0.code_out); end
    tests_run++; if (viol[0] !== 0) begin tests_failed++; $display("FAIL dup_pulse_rules: got %0d violations expected 0", viol[0]); end
  endtask

  task automatic test_back_to_back();
    logic v14;
    clear_mon();
    if0.code = 16'h1234;
    if0.enter_button = 1'b1;
    while (k < 34) begin
      tick();
      if (k == 4)  if0.enter_button = 1'b0;
      if (k == 8)  if0.enter_button = 1'b1;
      if (k == 10) if0.code = 16'h4321;
      if (k == 14) v14 = if0.code_valid;
      if (k == 18) if0.enter_button = 1'b0;
    end
    tests_run++; if (v14 !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_valid: got %b expected 1", v14); end
    tests_run++; if (n_valid[0] !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", n_valid[0]); end
    tests_run++; if (valid_k[0] !== 22) begin tests_failed++; $display("FAIL b2b_second_latency: got cycle %0d expected 22", valid_k[0]); end
    tests_run++; if (valid_code[0] !== 16'h4321) begin tests_failed++; $display("FAIL b2b_code_out: got %h expected 4321", valid_code[0]); end
  endtask

  task automatic test_ignore_busy();
    logic b8;
    clear_mon();
    if1.code = 16'h5678;
    if1.enter_button = 1'b1;
    while (k < 30) begin
      tick();
      if (k == 2)  if1.enter_button = 1'b0;
      if (k == 4)  if1.enter_button = 1'b1;
      if (k == 6)  if1.code = 16'h1111;
      if (k == 8)  b8 = if1.busy;
      if (k == 20) if1.enter_button = 1'b0;
    end
    tests_run++; if (b8 !== 1'b1) begin tests_failed++; $display("FAIL ignore_busy_at_repress: got %b expected 1", b8); end
    tests_run++; if (n_valid[1] !== 1) begin tests_failed++; $display("FAIL ignore_count: got %0d expected 1", n_valid[1]); end
    tests_run++; if (valid_k[1] !== 12) begin tests_failed++; $display("FAIL ignore_latency: got cycle %0d expected 12", valid_k[1]); end
    tests_run++; if (valid_code[1] !== 16'h5678) begin tests_failed++; $display("FAIL ignore_code_out: got %h expected 5678", valid_code[1]); end
    tests_run++; if (n_err[1] !== 0) begin tests_failed++; $display("FAIL ignore_no_error: got %0d expected 0", n_err[1]); end
  endtask

  task automatic test_reset_mid();
    logic b10;
    clear_mon();
    if0.code = 16'h9876;
    if0.enter_button = 1'b1;
    while (k < 10) tick();
    b10 = if0.busy;
    reset = 1'b1;
    if0.enter_button = 1'b0;
    tick();
    tests_run++; if (b10 !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before: got %b expected 1", b10); end
    tests_run++; if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy_after: got %b expected 0", if0.busy); end
    tests_run++; if (if0.code_out !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_code_out: got %h expected 0000", if0.code_out); end
    reset = 1'b0;
    repeat (25) tick();
    tests_run++; if (n_valid[0] + n_err[0] !== 0) begin tests_failed++; $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", n_valid[0] + n_err[0]); end
    press_run(16'h9876, 10, 30);
    tests_run++; if (valid_k[0] !== 14) begin tests_failed++; $display("FAIL rstmid_new_latency: got cycle %0d expected 14", valid_k[0]); end
    tests_run++; if (valid_code[0] !== 16'h9876) begin tests_failed++; $display("FAIL rstmid_new_code_out: got %h expected 9876", valid_code[0]); end
  endtask

  task automatic test_hex_digits();
    logic [1:0] exp_rsn;
`ifdef CODE_BCD_CHECK_EN
    exp_rsn = 2'd2;
`else
    exp_rsn = 2'd1;
`endif
    press_run(16'h1A1B, 10, 30);
    tests_run++; if (n_err[0] !== 1) begin tests_failed++; $display("FAIL hex_count: got %0d expected 1", n_err[0]); end
    tests_run++; if (err_k[0] !== 14) begin tests_failed++; $display("FAIL hex_latency: got cycle %0d expected 14", err_k[0]); end
    tests_run++; if (err_rsn[0] !== exp_rsn) begin tests_failed++; $display("FAIL hex_reason: got %0d expected %0d", err_rsn[0], exp_rsn); end
    tests_run++; if (if0.code_out !== 16'h9876) begin tests_failed++; $display("FAIL hex_code_out_kept: got %h expected 9876", if0.code_out); end
    press_run(16'hA0B1, 10, 30);
`ifdef CODE_BCD_CHECK_EN
    tests_run++; if (err_rsn[0] !== 2'd2 || n_err[0] !== 1) begin tests_failed++; $display("FAIL hex_unique_range: got reason %0d errors %0d expected 2 and 1", err_rsn[0], n_err[0]); end
`else
    tests_run++; if (valid_code[0] !== 16'hA0B1 || n_valid[0] !== 1) begin tests_failed++; $display("FAIL hex_unique_accept: got %h valids %0d expected a0b1 and 1", valid_code[0], n_valid[0]); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    if0.code = 16'h0000; if0.enter_button = 1'b0;
    if1.code = 16'h0000; if1.enter_button = 1'b0;
    clear_mon();
    test_reset();
    test_glitch();
    test_valid();
    test_dup();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_hex_digits();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
